// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, req/ack fetch from instruction memory,
// valid/ready delivery of {instr, pc}. Optional counter under FETCH_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        che,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count
);

  // Handshakes: imem_addr is held while imem_req=1 until imem_ack; a transfer
  // to the next stage happens on any cycle with if_valid=1 and if_ready=1.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_OUT = 2'd2;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic        discard, discard_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic        imem_req_n;
  logic [31:0] imem_addr_n;
  logic        if_valid_n;
  logic [31:0] if_instr_n;
  logic [31:0] if_pc_n;
  logic        xfer;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign xfer     = if_valid & if_ready;
  assign redir_pc = redirect_pc & ~32'h3;
  assign pc_inc   = pc + PC_STEP;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    discard_n    = discard;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    imem_req_n   = imem_req;
    imem_addr_n  = imem_addr;
    if_valid_n   = xfer ? 1'b0 : if_valid;
    if_instr_n   = if_instr;
    if_pc_n      = if_pc;

    if (redirect_valid) begin
      if_valid_n = 1'b0;
      pc_n       = redir_pc;
      if (state == S_REQ) begin
        // An unacked request cannot be withdrawn; its data is dropped later.
        if (imem_ack) begin
          discard_n   = 1'b0;
          imem_addr_n = redir_pc;
        end else begin
          discard_n = 1'b1;
        end
      end else begin
        state_n     = S_REQ;
        imem_req_n  = 1'b1;
        imem_addr_n = redir_pc;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_n     = S_REQ;
          imem_req_n  = 1'b1;
          imem_addr_n = pc;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (discard) begin
              discard_n   = 1'b0;
              imem_addr_n = pc;
            end else if (!if_valid || xfer) begin
              if_valid_n  = 1'b1;
              if_instr_n  = imem_rdata;
              if_pc_n     = imem_addr;
              pc_n        = pc_inc;
              imem_addr_n = pc_inc;
            end else begin
              hold_instr_n = imem_rdata;
              hold_pc_n    = imem_addr;
              imem_req_n   = 1'b0;
              state_n      = S_WAIT_OUT;
            end
          end
        end
        S_WAIT_OUT: begin
          if (xfer) begin
            if_valid_n  = 1'b1;
            if_instr_n  = hold_instr;
            if_pc_n     = hold_pc;
            pc_n        = pc_inc;
            imem_req_n  = 1'b1;
            imem_addr_n = pc_inc;
            state_n     = S_REQ;
          end
        end
        default: begin
          state_n    = S_IDLE;
          imem_req_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      discard    <= discard_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      imem_req   <= imem_req_n;
      imem_addr  <= imem_addr_n;
      if_valid   <= if_valid_n;
      if_instr   <= if_instr_n;
      if_pc      <= if_pc_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts delivered instructions; only reset clears it, redirects do not.
  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (xfer) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
`endif

endmodule
